fsm_bit_serializer: RTL and testbench
=====================================

Name: fsm_bit_serializer

Overview:
Parallel-in, serial-out stage that sits directly upstream of the sequence-detector FSM. It accepts a WIDTH-bit word through a valid/ready handshake and emits it one bit per clock on x_out. x_out connects straight to the FSM's x_in. Back-to-back words stream with no idle cycle, so the detector sees a continuous bit stream.

Parameters:
WIDTH, 8, word length in bits; legal range 2..32.
MSB_FIRST, 1, 1 = shift out the MSB first; 0 = shift out the LSB first.

Ports:
CLK  input  1  system clock; all state updates on the posedge.
Reset  input  1  asynchronous, active-high reset.
data_in  input  WIDTH  parallel word to serialize.
load_valid  input  1  data_in is valid this cycle.
load_ready  output  1  block can accept a word this cycle.
x_out  output  1  serial bit; drives the FSM x_in.
x_valid  output  1  x_out carries a word bit (or the parity bit) this cycle.
last_bit  output  1  high during the final bit of the current word.
busy  output  1  high while in SHIFT (or PARITY).

Behaviour:
- All outputs are registered, except load_ready, which is decoded combinationally from state.
- Reset (asserts asynchronously, at any time including mid-word):
  - state = IDLE; shift register and bit counter cleared.
  - x_out=0, x_valid=0, last_bit=0, busy=0.
  - The in-flight word is discarded.
- States: IDLE, SHIFT, plus PARITY only when PARITY_EN is defined.
- load_ready = (state==IDLE) || (last_bit && x_valid).
- A word is accepted only on a posedge where load_valid && load_ready.
- IDLE:
  - x_valid=0, x_out=0.
  - On accept: capture data_in, counter=0, go to SHIFT.
- Latency: a word accepted at edge k drives its first bit on x_out from edge k+1. Bit i (0-based, in shift order) is driven in cycle k+1+i.
- SHIFT:
  - Each edge advances one bit and increments the counter.
  - The counter is $clog2(WIDTH) bits wide and never exceeds WIDTH-1.
  - last_bit=1 while counter==WIDTH-1.
- End of word:
  - If a word is accepted on the last-bit edge: reload, counter=0, stay in SHIFT. The new word's first bit follows with no gap.
  - Otherwise: go to IDLE (or to PARITY when that feature is enabled).
- load_valid while load_ready=0 is ignored. data_in is not sampled and no error is flagged; the upstream source must hold its word until ready.
- load_valid and Reset together: Reset wins and the word is not captured.
- data_in is only sampled on the accept edge; changes at other times have no effect.

Optional Feature:
Macro: FSM_SER_PARITY_EN.
- Defined:
  - After the WIDTH data bits, one extra cycle in state PARITY drives x_out = XOR of all data bits (even parity), with x_valid=1.
  - last_bit moves to the parity cycle, and load_ready is high in that cycle.
  - Total bits per word = WIDTH+1.
- Undefined: the PARITY state and its logic are absent, and the word is exactly WIDTH bits.

Decomposition:
- Shared include/package fsm_ser_pkg:
  - State encodings IDLE=2'd0, SHIFT=2'd1, PARITY=2'd2.
  - Localparam CNT_W = $clog2(WIDTH).
- One sub-module is natural: fsm_ser_shiftreg, a loadable WIDTH-bit shift register with direction set by MSB_FIRST.
- The top level holds the FSM, the counter, and the parity accumulator.

Test Plan:
1. Reset=1 for 2 cycles, then 0 -> x_out=0, x_valid=0, busy=0, load_ready=1.
2. WIDTH=8, MSB_FIRST=1, load 8'hA5 at edge k -> x_out = 1,0,1,0,0,1,0,1 in cycles k+1..k+8; last_bit only in k+8; IDLE at k+9.
3. Load 8'hA5, then 8'h3C with load_valid held during the last-bit cycle -> 16 contiguous bits 10100101 00111100 with x_valid constantly 1.
4. Assert Reset asynchronously after 3 bits of 8'hF0 -> outputs zero immediately (before the next edge); after release, x_valid=0 until a new word is accepted.
5. Pulse load_valid with 8'hFF while in the middle of a word -> ignored and load_ready=0; the stream continues unchanged. MSB_FIRST=0 with 8'h01 -> x_out = 1,0,0,0,0,0,0,0.
6. With FSM_SER_PARITY_EN defined: 8'hA5 -> 9th bit 0; 8'h07 -> 9th bit 1. End-to-end through the detector FSM: the y_out sequence matches the golden vector file.

Source files
------------

// File: rtl/fsm_ser_pkg.sv
// fsm_ser_pkg: shared state encoding and counter sizing for the bit serializer
package fsm_ser_pkg;
  typedef enum logic [1:0] {IDLE = 2'd0, SHIFT = 2'd1, PARITY = 2'd2} state_t;
  function automatic int cnt_w(input int w);
    return $clog2(w);
  endfunction
endpackage

// File: rtl/fsm_ser_shiftreg.sv
// fsm_ser_shiftreg: loadable shift register presenting the first bit of the incoming word and the next bit of the held word
module fsm_ser_shiftreg #(
  parameter int WIDTH = 8,
  parameter bit MSB_FIRST = 1'b1
) (
  input  logic             CLK,
  input  logic             Reset,
  input  logic             load,
  input  logic             shift,
  input  logic [WIDTH-1:0] d,
  output logic             first,
  output logic             nxt
);
  logic [WIDTH-1:0] q;
  always_ff @(posedge CLK or posedge Reset)
    if (Reset) q <= '0;
    else if (load) q <= d;
    else if (shift) q <= MSB_FIRST ? q << 1 : q >> 1;
  assign first = MSB_FIRST ? d[WIDTH-1] : d[0];
  assign nxt   = MSB_FIRST ? q[WIDTH-2] : q[1];
endmodule

// File: rtl/fsm_bit_serializer.sv
// fsm_bit_serializer: valid/ready parallel-in serial-out stage feeding the sequence detector.
// Define FSM_SER_PARITY_EN to append an even-parity bit after each word.
module fsm_bit_serializer
  import fsm_ser_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter bit MSB_FIRST = 1'b1
) (
  input  logic             CLK,
  input  logic             Reset,
  input  logic [WIDTH-1:0] data_in,
  input  logic             load_valid,
  output logic             load_ready,
  output logic             x_out,
  output logic             x_valid,
  output logic             last_bit,
  output logic             busy
);
  localparam int CNT_W = cnt_w(WIDTH);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(WIDTH - 1);
`ifdef FSM_SER_PARITY_EN
  localparam bit DATA_LAST = 1'b0;
`else
  localparam bit DATA_LAST = 1'b1;
`endif
  state_t           state;
  logic [CNT_W-1:0] cnt;
  logic             accept, advance, first, nxt;
  assign load_ready = (state == IDLE) || (last_bit && x_valid);
  assign accept     = load_valid && load_ready;
  assign advance    = (state == SHIFT) && (cnt != LAST);
  fsm_ser_shiftreg #(.WIDTH(WIDTH), .MSB_FIRST(MSB_FIRST)) u_sr (
    .CLK(CLK), .Reset(Reset), .load(accept), .shift(advance),
    .d(data_in), .first(first), .nxt(nxt)
  );
`ifdef FSM_SER_PARITY_EN
  logic par;
  always_ff @(posedge CLK or posedge Reset)
    if (Reset) par <= 1'b0;
    else if (accept) par <= ^data_in;
`endif
  // Accept takes priority so a word loaded on the last-bit edge streams without a gap
  always_ff @(posedge CLK or posedge Reset)
    if (Reset) begin
      state    <= IDLE;
      cnt      <= '0;
      x_out    <= 1'b0;
      x_valid  <= 1'b0;
      last_bit <= 1'b0;
      busy     <= 1'b0;
    end else if (accept) begin
      state    <= SHIFT;
      cnt      <= '0;
      x_out    <= first;
      x_valid  <= 1'b1;
      last_bit <= 1'b0;
      busy     <= 1'b1;
    end else if (advance) begin
      cnt      <= cnt + 1'b1;
      x_out    <= nxt;
      last_bit <= DATA_LAST && (cnt == LAST - 1'b1);
`ifdef FSM_SER_PARITY_EN
    end else if (state == SHIFT) begin
      state    <= PARITY;
      x_out    <= par;
      last_bit <= 1'b1;
`endif
    end else begin
      state    <= IDLE;
      x_out    <= 1'b0;
      x_valid  <= 1'b0;
      last_bit <= 1'b0;
      busy     <= 1'b0;
    end
endmodule

// File: tb/tb_fsm_bit_serializer.sv
// tb_fsm_bit_serializer: directed self-checking bench for fsm_bit_serializer (MSB-first and LSB-first instances).
module tb_fsm_bit_serializer;
`ifdef FSM_SER_PARITY_EN
  localparam int NB = 9;
`else
  localparam int NB = 8;
`endif
  logic CLK_TB = 1'b0;
  logic Reset = 1'b1;
  logic [7:0] data_in = '0;
  logic load_valid = 1'b0;
  logic load_ready, x_out, x_valid, last_bit, busy;
  logic [7:0] lsb_data = '0;
  logic lsb_valid = 1'b0;
  logic lsb_ready, lsb_x, lsb_xv, lsb_last, lsb_busy;
  int checks = 0;
  int errors = 0;

  always #5 CLK_TB = ~CLK_TB;

  fsm_bit_serializer #(.WIDTH(8), .MSB_FIRST(1'b1)) dut (
    .CLK(CLK_TB), .Reset(Reset), .data_in(data_in), .load_valid(load_valid),
    .load_ready(load_ready), .x_out(x_out), .x_valid(x_valid),
    .last_bit(last_bit), .busy(busy)
  );

  fsm_bit_serializer #(.WIDTH(8), .MSB_FIRST(1'b0)) dut_lsb (
    .CLK(CLK_TB), .Reset(Reset), .data_in(lsb_data), .load_valid(lsb_valid),
    .load_ready(lsb_ready), .x_out(lsb_x), .x_valid(lsb_xv),
    .last_bit(lsb_last), .busy(lsb_busy)
  );

  function automatic logic exp_bit(input logic [7:0] w, input int i, input bit msb);
    return i >= 8 ? ^w : (msb ? w[7-i] : w[i]);
  endfunction

  task automatic tick();
    @(posedge CLK_TB);
    #1;
  endtask

  task automatic test_reset();
    Reset = 1'b1;
    load_valid = 1'b1;
    data_in = 8'hFF;
    tick();
    tick();
    load_valid = 1'b0;
    Reset = 1'b0;
    tick();
    checks++; if (x_out !== 1'b0) begin errors++; $display("FAIL reset_x_out got %b exp 0", x_out); end
    checks++; if (x_valid !== 1'b0) begin errors++; $display("FAIL reset_x_valid got %b exp 0", x_valid); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b exp 0", busy); end
    checks++; if (last_bit !== 1'b0) begin errors++; $display("FAIL reset_last_bit got %b exp 0", last_bit); end
    checks++; if (load_ready !== 1'b1) begin errors++; $display("FAIL reset_load_ready got %b exp 1", load_ready); end
  endtask

  task automatic test_single();
    data_in = 8'hA5;
    load_valid = 1'b1;
    tick();
    load_valid = 1'b0;
    data_in = 8'h00;
    for (int i = 0; i < NB; i++) begin
      checks++; if (x_out !== exp_bit(8'hA5, i, 1'b1)) begin errors++; $display("FAIL single_x_out bit %0d got %b exp %b", i, x_out, exp_bit(8'hA5, i, 1'b1)); end
      checks++; if (x_valid !== 1'b1) begin errors++; $display("FAIL single_x_valid bit %0d got %b exp 1", i, x_valid); end
      checks++; if (last_bit !== (i == NB - 1)) begin errors++; $display("FAIL single_last_bit bit %0d got %b exp %b", i, last_bit, i == NB - 1); end
      checks++; if (load_ready !== (i == NB - 1)) begin errors++; $display("FAIL single_load_ready bit %0d got %b exp %b", i, load_ready, i == NB - 1); end
      tick();
    end
    checks++; if (x_valid !== 1'b0) begin errors++; $display("FAIL single_idle_x_valid got %b exp 0", x_valid); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL single_idle_busy got %b exp 0", busy); end
    checks++; if (load_ready !== 1'b1) begin errors++; $display("FAIL single_idle_ready got %b exp 1", load_ready); end
  endtask

  task automatic test_back_to_back();
    logic [7:0] words [2];
    words[0] = 8'hA5;
    words[1] = 8'h3C;
    data_in = words[0];
    load_valid = 1'b1;
    tick();
    load_valid = 1'b0;
    for (int w = 0; w < 2; w++)
      for (int i = 0; i < NB; i++) begin
        checks++; if (x_out !== exp_bit(words[w], i, 1'b1)) begin errors++; $display("FAIL b2b_x_out word %0d bit %0d got %b exp %b", w, i, x_out, exp_bit(words[w], i, 1'b1)); end
        checks++; if (x_valid !== 1'b1) begin errors++; $display("FAIL b2b_x_valid word %0d bit %0d got %b exp 1", w, i, x_valid); end
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL b2b_busy word %0d bit %0d got %b exp 1", w, i, busy); end
        if (w == 0 && i == NB - 1) begin
          data_in = words[1];
          load_valid = 1'b1;
        end
        tick();
        load_valid = 1'b0;
      end
    checks++; if (x_valid !== 1'b0) begin errors++; $display("FAIL b2b_end_x_valid got %b exp 0", x_valid); end
  endtask

  task automatic test_async_reset();
    data_in = 8'hF0;
    load_valid = 1'b1;
    tick();
    load_valid = 1'b0;
    tick();
    tick();
    checks++; if (x_out !== 1'b1 || x_valid !== 1'b1) begin errors++; $display("FAIL areset_pre got x_out=%b x_valid=%b exp 1 1", x_out, x_valid); end
    #2 Reset = 1'b1;
    #1;
    checks++; if (x_out !== 1'b0) begin errors++; $display("FAIL areset_x_out got %b exp 0", x_out); end
    checks++; if (x_valid !== 1'b0) begin errors++; $display("FAIL areset_x_valid got %b exp 0", x_valid); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL areset_busy got %b exp 0", busy); end
    #2 Reset = 1'b0;
    tick();
    tick();
    checks++; if (x_valid !== 1'b0) begin errors++; $display("FAIL areset_after_x_valid got %b exp 0", x_valid); end
    checks++; if (load_ready !== 1'b1) begin errors++; $display("FAIL areset_after_ready got %b exp 1", load_ready); end
  endtask

  task automatic test_ignore_midword();
    data_in = 8'hC3;
    load_valid = 1'b1;
    tick();
    load_valid = 1'b0;
    for (int i = 0; i < NB; i++) begin
      if (i == 3) begin
        data_in = 8'hFF;
        load_valid = 1'b1;
        checks++; if (load_ready !== 1'b0) begin errors++; $display("FAIL ignore_ready got %b exp 0", load_ready); end
      end
      checks++; if (x_out !== exp_bit(8'hC3, i, 1'b1)) begin errors++; $display("FAIL ignore_x_out bit %0d got %b exp %b", i, x_out, exp_bit(8'hC3, i, 1'b1)); end
      tick();
      load_valid = 1'b0;
    end
    checks++; if (x_valid !== 1'b0) begin errors++; $display("FAIL ignore_end_x_valid got %b exp 0", x_valid); end
  endtask

  task automatic test_lsb_first();
    lsb_data = 8'h01;
    lsb_valid = 1'b1;
    tick();
    lsb_valid = 1'b0;
    for (int i = 0; i < NB; i++) begin
      checks++; if (lsb_x !== exp_bit(8'h01, i, 1'b0)) begin errors++; $display("FAIL lsb_x_out bit %0d got %b exp %b", i, lsb_x, exp_bit(8'h01, i, 1'b0)); end
      checks++; if (lsb_last !== (i == NB - 1)) begin errors++; $display("FAIL lsb_last_bit bit %0d got %b exp %b", i, lsb_last, i == NB - 1); end
      tick();
    end
    checks++; if (lsb_xv !== 1'b0 || lsb_busy !== 1'b0) begin errors++; $display("FAIL lsb_idle got x_valid=%b busy=%b exp 0 0", lsb_xv, lsb_busy); end
  endtask

`ifdef FSM_SER_PARITY_EN
  task automatic test_parity();
    logic [7:0] words [2];
    logic       pbits [2];
    words[0] = 8'hA5; pbits[0] = 1'b0;
    words[1] = 8'h07; pbits[1] = 1'b1;
    for (int w = 0; w < 2; w++) begin
      data_in = words[w];
      load_valid = 1'b1;
      tick();
      load_valid = 1'b0;
      for (int i = 0; i < 8; i++) tick();
      checks++; if (x_out !== pbits[w] || x_valid !== 1'b1 || last_bit !== 1'b1) begin errors++; $display("FAIL parity word %0d got x_out=%b x_valid=%b last=%b exp %b 1 1", w, x_out, x_valid, last_bit, pbits[w]); end
      tick();
    end
  endtask
`endif

  initial begin
    test_reset();
    test_single();
    test_back_to_back();
    test_async_reset();
    test_ignore_midword();
    test_lsb_first();
`ifdef FSM_SER_PARITY_EN
    test_parity();
`endif
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
